// File: rtl/mpu_add_sequencer.sv
// Streaming 5x5 matrix adder: buffers A, adds each arriving B element to the
// matching A element, and emits row-major results through a one-entry output register.
module mpu_add_sequencer #(
  parameter int DIM   = 5,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic [2:0]       out_row,
  output logic [2:0]       out_col,
  output logic             ovf_any
);

  localparam int N  = DIM * DIM;
  localparam int KW = $clog2(N);

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, FLUSH} state_t;

  state_t           r_state;
  logic [KW-1:0]    r_k;
  logic [2:0]       r_row;
  logic [2:0]       r_col;
  logic [WIDTH-1:0] r_a_mem [N];

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_last;
  logic [WIDTH:0]   w_sum;

  // The output register is a one-entry skid: B is accepted whenever the
  // current result leaves in the same cycle, so continuous flow has no bubble.
  assign in_ready   = (r_state == LOAD_A) ||
                      ((r_state == LOAD_B) && (!out_valid || out_ready));
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;
  assign w_last     = (r_k == KW'(N - 1));
  assign w_sum      = {1'b0, r_a_mem[r_k]} + {1'b0, in_data};

  // NOTE: the A buffer has no reset; every entry is rewritten in LOAD_A before
  // it is read, so resetting it would only cost flops' reset routing.
  always_ff @(posedge clk) begin
    if ((r_state == LOAD_A) && w_in_xfer && !abort)
      r_a_mem[r_k] <= in_data;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_row     <= '0;
      r_col     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      ovf_any   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_out_xfer)
        out_valid <= 1'b0;

      if (abort) begin
        r_state   <= IDLE;
        busy      <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        if (w_in_xfer) begin
          if (w_last) begin
            r_k   <= '0;
            r_row <= '0;
            r_col <= '0;
          end else begin
            r_k <= r_k + 1'b1;
            if (r_col == 3'(DIM - 1)) begin
              r_col <= '0;
              r_row <= r_row + 3'd1;
            end else begin
              r_col <= r_col + 3'd1;
            end
          end
        end

        case (r_state)
          IDLE: begin
            if (start) begin
              r_state <= LOAD_A;
              busy    <= 1'b1;
              r_k     <= '0;
              r_row   <= '0;
              r_col   <= '0;
              ovf_any <= 1'b0;
            end
          end
          LOAD_A: begin
            if (w_in_xfer && w_last)
              r_state <= LOAD_B;
          end
          LOAD_B: begin
            if (w_in_xfer) begin
              out_valid <= 1'b1;
              out_data  <= w_sum[WIDTH-1:0];
              out_carry <= w_sum[WIDTH];
              out_row   <= r_row;
              out_col   <= r_col;
              ovf_any   <= ovf_any | w_sum[WIDTH];
              if (w_last)
                r_state <= FLUSH;
            end
          end
          FLUSH: begin
            if (!out_valid || w_out_xfer) begin
              r_state <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mpu_add_sequencer.sv
// Directed bench for mpu_add_sequencer: full runs, carry wrap, backpressure,
// abort, start-while-busy, mid-operation reset and IDLE input rejection.
module tb_mpu_add_sequencer;

  localparam int DIM   = 5;
  localparam int WIDTH = 8;
  localparam int N     = DIM * DIM;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic [2:0]       out_row;
  logic [2:0]       out_col;
  logic             ovf_any;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] a_v [N];
  logic [WIDTH-1:0] b_v [N];

  mpu_add_sequencer #(.DIM(DIM), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_row   (out_row),
    .out_col   (out_col),
    .ovf_any   (ovf_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation. Inputs change at negedge; DUT outputs are sampled 1 ns later,
  // well away from the rising edge that acts on them.
  task automatic run_op(input bit bp, input int abort_at, input int rst_at,
                        input bit start_in_a, input bit idle_junk);
    int               bi;
    int               oi;
    int               cyc;
    int               dones;
    bit               stalled;
    bit               exp_ovf;
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] h_data;
    logic             h_carry;
    logic [2:0]       h_row;
    logic [2:0]       h_col;

    exp_ovf = 1'b0;
    h_data = '0; h_carry = 1'b0; h_row = '0; h_col = '0;

    if (idle_junk) begin
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'b1;
        in_data  = 8'hAA;
        #1;
        check("idle_in_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        @(negedge clk);
      end
    end

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    #1;
    check("busy_after_start", busy, 1);

    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = a_v[i];
      start    = start_in_a && (i == 5);
      #1;
      check("a_in_ready", in_ready, 1);
      @(negedge clk);
    end
    start = 1'b0;

    bi = 0; oi = 0; cyc = 0; dones = 0; stalled = 1'b0;
    while (oi < N && cyc < 400) begin
      if (abort_at >= 0 && bi == abort_at) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = b_v[bi];
        abort     = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_ovf_kept", ovf_any, 1);
        for (int i = 0; i < 3; i++) begin
          check("abort_no_done", done, 0);
          @(negedge clk);
          #1;
        end
        out_ready = 1'b1;
        return;
      end
      if (rst_at >= 0 && bi == rst_at) begin
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_carry", out_carry, 0);
        check("rst_ovf_any", ovf_any, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_col", out_col, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        return;
      end

      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      in_valid  = (bi < N);
      in_data   = (bi < N) ? b_v[bi] : '0;
      #1;
      if (done) dones++;
      if (bi < N)
        check("b_in_ready", in_ready, !out_valid || out_ready);
      if (stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, h_data);
        check("hold_carry", out_carry, h_carry);
        check("hold_row", out_row, h_row);
        check("hold_col", out_col, h_col);
      end
      if (out_valid && out_ready) begin
        s = {1'b0, a_v[oi]} + {1'b0, b_v[oi]};
        check("out_data", out_data, s[WIDTH-1:0]);
        check("out_carry", out_carry, s[WIDTH]);
        check("out_row", out_row, oi / DIM);
        check("out_col", out_col, oi % DIM);
        exp_ovf = exp_ovf | s[WIDTH];
        oi++;
      end
      stalled = out_valid && !out_ready;
      h_data = out_data; h_carry = out_carry; h_row = out_row; h_col = out_col;
      if (in_valid && in_ready) bi++;
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;

    check("result_count", oi, N);
    check("done_early", dones, 0);
    #1;
    check("done_pulse", done, 1);
    check("busy_end", busy, 0);
    check("ovf_any_end", ovf_any, exp_ovf);
    @(negedge clk);
    #1;
    check("done_single", done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_ovf_any", ovf_any, 0);
    check("reset_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // A=k, B=2k with junk words offered in IDLE first: sums 3k, no carries
    for (int i = 0; i < N; i++) begin a_v[i] = 8'(i); b_v[i] = 8'(2 * i); end
    run_op(1'b0, -1, -1, 1'b0, 1'b1);

    // 0xFF + 0x02 wraps to 0x01 with carry everywhere
    for (int i = 0; i < N; i++) begin a_v[i] = 8'hFF; b_v[i] = 8'h02; end
    run_op(1'b0, -1, -1, 1'b0, 1'b0);

    // Backpressure with mixed carry/no-carry data
    for (int i = 0; i < N; i++) begin a_v[i] = 8'(i * 37); b_v[i] = 8'(200 - i * 3); end
    run_op(1'b1, -1, -1, 1'b0, 1'b0);

    // Abort after 10 B elements, then a clean full run
    for (int i = 0; i < N; i++) begin a_v[i] = 8'(8'hF0 + i); b_v[i] = 8'(8'h10 + i); end
    run_op(1'b0, 10, -1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin a_v[i] = 8'(i); b_v[i] = 8'(2 * i); end
    run_op(1'b0, -1, -1, 1'b0, 1'b0);

    // start during LOAD_A must not disturb k; then reset mid-LOAD_B
    for (int i = 0; i < N; i++) begin a_v[i] = 8'(8'hF0 + i); b_v[i] = 8'(8'h10 + i); end
    run_op(1'b0, -1, 7, 1'b1, 1'b0);

    // Recovery after reset
    for (int i = 0; i < N; i++) begin a_v[i] = 8'(i * 11); b_v[i] = 8'(i * 13); end
    run_op(1'b0, -1, -1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
